// File: rtl/lfsr_stream_packet_gen.sv
// ---------------------------------------------------------------------------
// lfsr_stream_packet_gen
//
// Streaming packet generator. Sends a programmable number of packets over a
// valid/ready interface. Each packet is len words long and carries either a
// PRBS payload or the word index. A programmable number of idle cycles can
// be placed between packets. A graceful stop lets the packet in flight
// finish before the generator goes idle.
//
// Ports:
//   clk           clock; all logic on the rising edge
//   rst           synchronous, active-high reset
//   start         one-cycle run request; accepted only in IDLE
//   stop          graceful stop; held internally until honoured
//   cfg_len       words per packet (0 treated as 1), latched on start
//   cfg_num_pkts  packets per run (0 = run until stop), latched on start
//   cfg_gap       idle cycles between packets, latched on start
//   cfg_mode      0 = PRBS payload, 1 = word-index payload, latched on start
//   m_data        payload word
//   m_valid       m_data is valid
//   m_last        final word of a packet
//   m_ready       sink ready; a beat transfers on m_valid & m_ready
//   busy          high while in SEND or GAP
//   pkt_done      one-cycle pulse per completed packet
//   pkt_count     packets completed since reset (wraps)
// ---------------------------------------------------------------------------
module lfsr_stream_packet_gen #(
  parameter int          DATA_W    = 32,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_1234,
  parameter int          LEN_W     = 16,
  parameter int          GAP_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [15:0]       cfg_num_pkts,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic              cfg_mode,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              pkt_done,
  output logic [31:0]       pkt_count
);

  localparam int NLANES = (DATA_W + 31) / 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Run configuration captured on the start cycle
  logic [LEN_W-1:0] len_reg, len_next;
  logic [15:0]      num_reg, num_next;
  logic [GAP_W-1:0] gap_reg, gap_next;
  logic             mode_reg, mode_next;

  // Run progress
  logic [LEN_W-1:0] idx_reg, idx_next;
  logic [15:0]      sent_reg, sent_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic             stop_pend_reg, stop_pend_next;

  logic             pkt_done_reg, pkt_done_next;
  logic [31:0]      pkt_count_reg, pkt_count_next;

  logic                   xfer;
  logic                   last_beat;
  logic                   stop_eff;
  logic                   run_done;
  logic [NLANES*32-1:0]   lanes_cat;
  logic [DATA_W-1:0]      idx_word;

  assign xfer      = (state_reg == SEND) && m_ready;
  assign last_beat = (idx_reg == len_reg - LEN_W'(1));
  // A stop seen in the same cycle as the deciding event counts immediately
  assign stop_eff  = stop_pend_reg | stop;
  assign run_done  = (num_reg != 16'd0) && ((sent_reg + 16'd1) == num_reg);

  // -------------------------------------------------------------------------
  // PRBS lanes: one 32-bit Fibonacci LFSR per 32 bits of payload, each with
  // its own seed. They advance only on a transfer and are reseeded only by
  // rst, so the sequence continues across packets and runs.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NLANES; gi++) begin : g_lane
      localparam logic [31:0] SEED_RAW = LFSR_SEED ^ (32'(gi) * 32'h9E37_79B9);
      // An all-zero LFSR would lock up, so a zero seed is replaced
      localparam logic [31:0] SEED     = (SEED_RAW == 32'd0) ? 32'd1 : SEED_RAW;

      logic [31:0] lane_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          lane_reg <= SEED;
        end else if (xfer) begin
          lane_reg <= {lane_reg[30:0],
                       lane_reg[31] ^ lane_reg[21] ^ lane_reg[1] ^ lane_reg[0]};
        end
      end

      assign lanes_cat[gi*32 +: 32] = lane_reg;
    end

    // Word index zero-extended or truncated to the payload width
    for (gi = 0; gi < DATA_W; gi++) begin : g_idx
      if (gi < LEN_W) begin : g_bit
        assign idx_word[gi] = idx_reg[gi];
      end else begin : g_zero
        assign idx_word[gi] = 1'b0;
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // FSM state register and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      num_reg       <= '0;
      gap_reg       <= '0;
      mode_reg      <= 1'b0;
      idx_reg       <= '0;
      sent_reg      <= '0;
      gap_cnt_reg   <= '0;
      stop_pend_reg <= 1'b0;
      pkt_done_reg  <= 1'b0;
      pkt_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      num_reg       <= num_next;
      gap_reg       <= gap_next;
      mode_reg      <= mode_next;
      idx_reg       <= idx_next;
      sent_reg      <= sent_next;
      gap_cnt_reg   <= gap_cnt_next;
      stop_pend_reg <= stop_pend_next;
      pkt_done_reg  <= pkt_done_next;
      pkt_count_reg <= pkt_count_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    num_next       = num_reg;
    gap_next       = gap_reg;
    mode_next      = mode_reg;
    idx_next       = idx_reg;
    sent_next      = sent_reg;
    gap_cnt_next   = gap_cnt_reg;
    // stop is remembered only while a run is active
    stop_pend_next = stop_pend_reg | (stop && (state_reg != IDLE));
    pkt_done_next  = 1'b0;
    pkt_count_next = pkt_count_reg;

    case (state_reg)
      IDLE: begin
        stop_pend_next = 1'b0;
        if (start) begin
          state_next = SEND;
          len_next   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
          num_next   = cfg_num_pkts;
          gap_next   = cfg_gap;
          mode_next  = cfg_mode;
          idx_next   = '0;
          sent_next  = '0;
        end
      end

      SEND: begin
        if (xfer) begin
          if (last_beat) begin
            pkt_done_next  = 1'b1;
            pkt_count_next = pkt_count_reg + 32'd1;
            idx_next       = '0;
            sent_next      = sent_reg + 16'd1;
            if (run_done || stop_eff) begin
              state_next     = IDLE;
              stop_pend_next = 1'b0;
            end else if (gap_reg != '0) begin
              state_next   = GAP;
              gap_cnt_next = gap_reg;
            end
          end else begin
            idx_next = idx_reg + LEN_W'(1);
          end
        end
      end

      GAP: begin
        if (stop_eff) begin
          state_next     = IDLE;
          stop_pend_next = 1'b0;
        end else if (gap_cnt_reg == GAP_W'(1)) begin
          // Counter was loaded with gap, so this is the last idle cycle
          state_next = SEND;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs (data is forced to zero outside SEND so reset/idle read as 0)
  // -------------------------------------------------------------------------
  assign m_valid   = (state_reg == SEND);
  assign busy      = (state_reg != IDLE);
  assign m_last    = m_valid && last_beat;
  assign m_data    = !m_valid ? '0 :
                     (mode_reg ? idx_word : lanes_cat[DATA_W-1:0]);
  assign pkt_done  = pkt_done_reg;
  assign pkt_count = pkt_count_reg;

endmodule

// File: tb/tb_lfsr_stream_packet_gen.sv
// ---------------------------------------------------------------------------
// tb_lfsr_stream_packet_gen
//
// Directed bench for lfsr_stream_packet_gen with default parameters.
// Inputs are driven and outputs observed 1 time unit after each rising
// edge; a beat seen with m_valid & m_ready transfers on the next edge.
// ---------------------------------------------------------------------------
module tb_lfsr_stream_packet_gen;

  localparam int          DATA_W = 32;
  localparam int          LEN_W  = 16;
  localparam int          GAP_W  = 8;
  localparam logic [31:0] SEED   = 32'hACE1_1234;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic [15:0]       cfg_num_pkts = '0;
  logic [GAP_W-1:0]  cfg_gap = '0;
  logic              cfg_mode = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready = 1'b1;
  logic              busy;
  logic              pkt_done;
  logic [31:0]       pkt_count;

  always #5 clk = ~clk;

  lfsr_stream_packet_gen #(
    .DATA_W    (DATA_W),
    .LFSR_SEED (SEED),
    .LEN_W     (LEN_W),
    .GAP_W     (GAP_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .cfg_len      (cfg_len),
    .cfg_num_pkts (cfg_num_pkts),
    .cfg_gap      (cfg_gap),
    .cfg_mode     (cfg_mode),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .busy         (busy),
    .pkt_done     (pkt_done),
    .pkt_count    (pkt_count)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_lfsr;
  logic [31:0] exp_count;

  // Per-run observation
  logic [31:0] bd[$];
  logic [31:0] ep[$];
  logic        bl[$];
  logic        vtr[$];
  int          done_cnt;
  int          end_cyc;
  int          stop_cyc;

  // Stimulus knobs for collect_run
  int hold_beat;
  int hold_len;
  int mid_start_cyc;
  int stop_beat;
  bit stop_in_gap;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [31:0] got_d(input int i);
    if (i < bd.size()) return bd[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] pack_last();
    logic [31:0] r = '0;
    for (int i = 0; i < bl.size() && i < 32; i++) r[i] = bl[i];
    return r;
  endfunction

  function automatic logic [31:0] pack_valid();
    logic [31:0] r = '0;
    for (int i = 0; i < vtr.size() && i < 32; i++) r[i] = vtr[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic default_knobs();
    hold_beat     = -1;
    hold_len      = 0;
    mid_start_cyc = -1;
    stop_beat     = -1;
    stop_in_gap   = 1'b0;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    m_ready = 1'b1;
    tick();
    tick();
    rst       = 1'b0;
    exp_lfsr  = SEED;
    exp_count = 32'd0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_cfg(input int len, input int num, input int gap, input bit mode);
    cfg_len      = LEN_W'(len);
    cfg_num_pkts = 16'(num);
    cfg_gap      = GAP_W'(gap);
    cfg_mode     = mode;
  endtask

  // Runs cycle by cycle from the first beat until busy drops, recording
  // transfers, the valid trace and pkt_done pulses.
  task automatic collect_run(input int max_cyc);
    int          hold_left = hold_len;
    logic        stalled = 1'b0;
    logic [31:0] held_d = '0;
    logic        held_l = 1'b0;
    bit          timed_out = 1'b1;
    bd.delete(); ep.delete(); bl.delete(); vtr.delete();
    done_cnt = 0;
    end_cyc  = -1;
    stop_cyc = -1;
    for (int c = 0; c < max_cyc; c++) begin
      if (stalled) begin
        check_val("stall_valid", m_valid, 1);
        check_val("stall_data", m_data, held_d);
        check_val("stall_last", m_last, held_l);
      end
      m_ready = 1'b1;
      if (hold_left > 0 && bd.size() == hold_beat && m_valid) begin
        m_ready = 1'b0;
        hold_left--;
      end
      start = (c == mid_start_cyc);
      stop  = 1'b0;
      if (stop_beat >= 0 && bd.size() == stop_beat && m_valid && stop_cyc < 0) begin
        stop     = 1'b1;
        stop_cyc = c;
      end
      if (stop_in_gap && bd.size() > 0 && busy && !m_valid && stop_cyc < 0) begin
        stop     = 1'b1;
        stop_cyc = c;
      end
      vtr.push_back(m_valid);
      stalled = m_valid && !m_ready;
      held_d  = m_data;
      held_l  = m_last;
      if (m_valid && m_ready) begin
        bd.push_back(m_data);
        bl.push_back(m_last);
        ep.push_back(exp_lfsr);
        exp_lfsr = lfsr_next(exp_lfsr);
      end
      if (pkt_done) done_cnt++;
      if (!busy) begin
        end_cyc   = c;
        timed_out = 1'b0;
        break;
      end
      tick();
    end
    start   = 1'b0;
    stop    = 1'b0;
    m_ready = 1'b1;
    check_val("run_timeout", timed_out, 0);
  endtask

  initial begin
    default_knobs();

    // 1: reset state, then one 4-beat PRBS packet
    do_reset();
    check_val("rst_valid", m_valid, 0);
    check_val("rst_data", m_data, 0);
    check_val("rst_last", m_last, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", pkt_done, 0);
    check_val("rst_count", pkt_count, 0);
    set_cfg(4, 1, 0, 1'b0);
    pulse_start();
    check_val("s1_latency", m_valid, 1);
    collect_run(50);
    check_val("s1_beats", bd.size(), 4);
    check_val("s1_d0", got_d(0), 32'hACE11234);
    check_val("s1_d1", got_d(1), 32'h59C22468);
    check_val("s1_d2", got_d(2), 32'hB38448D0);
    check_val("s1_d3", got_d(3), 32'h670891A1);
    check_val("s1_last", pack_last(), 32'b1000);
    check_val("s1_done", done_cnt, 1);
    exp_count += 32'd1;
    check_val("s1_count", pkt_count, exp_count);
    check_val("s1_busy", busy, 0);

    // 2: same packet with ready low for 3 cycles at beat 2
    do_reset();
    set_cfg(4, 1, 0, 1'b0);
    hold_beat = 1;
    hold_len  = 3;
    pulse_start();
    collect_run(50);
    default_knobs();
    check_val("s2_beats", bd.size(), 4);
    check_val("s2_cycles", vtr.size(), 8);
    check_val("s2_d0", got_d(0), 32'hACE11234);
    check_val("s2_d1", got_d(1), 32'h59C22468);
    check_val("s2_d2", got_d(2), 32'hB38448D0);
    check_val("s2_d3", got_d(3), 32'h670891A1);
    check_val("s2_last", pack_last(), 32'b1000);
    exp_count += 32'd1;
    check_val("s2_count", pkt_count, exp_count);

    // 3: stop in IDLE is not stored; index payload with gap 2;
    //    cfg changes after start are ignored
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_val("s3_idle_stop", busy, 0);
    set_cfg(4, 3, 2, 1'b1);
    pulse_start();
    set_cfg(9, 1, 0, 1'b0);
    collect_run(100);
    check_val("s3_beats", bd.size(), 12);
    for (int i = 0; i < 12; i++) check_val($sformatf("s3_d%0d", i), got_d(i), 32'(i % 4));
    check_val("s3_last", pack_last(), 32'b1000_1000_1000);
    check_val("s3_cycles", vtr.size(), 17);
    check_val("s3_valid", pack_valid(), 32'h0000_F3CF);
    check_val("s3_done", done_cnt, 3);
    exp_count += 32'd3;
    check_val("s3_count", pkt_count, exp_count);

    // 4: back-to-back packets, start mid-run ignored
    set_cfg(5, 2, 0, 1'b0);
    mid_start_cyc = 3;
    pulse_start();
    collect_run(100);
    default_knobs();
    check_val("s4_beats", bd.size(), 10);
    for (int i = 0; i < 10; i++) check_val($sformatf("s4_d%0d", i), got_d(i), ep[i]);
    check_val("s4_last", pack_last(), 32'h210);
    check_val("s4_cycles", vtr.size(), 11);
    check_val("s4_valid", pack_valid(), 32'h3FF);
    check_val("s4_done", done_cnt, 2);
    exp_count += 32'd2;
    check_val("s4_count", pkt_count, exp_count);

    // 5a: continuous run, stop during beat 2 -> packet completes
    set_cfg(8, 0, 0, 1'b1);
    stop_beat = 1;
    pulse_start();
    collect_run(200);
    default_knobs();
    check_val("s5a_beats", bd.size(), 8);
    for (int i = 0; i < 8; i++) check_val($sformatf("s5a_d%0d", i), got_d(i), 32'(i));
    check_val("s5a_last", pack_last(), 32'h80);
    check_val("s5a_done", done_cnt, 1);
    exp_count += 32'd1;
    check_val("s5a_count", pkt_count, exp_count);

    // 5b: continuous run with gap 6, stop in GAP -> IDLE next cycle
    set_cfg(8, 0, 6, 1'b1);
    stop_in_gap = 1'b1;
    pulse_start();
    collect_run(200);
    default_knobs();
    check_val("s5b_beats", bd.size(), 8);
    check_val("s5b_stop_cyc", stop_cyc, 8);
    check_val("s5b_end_cyc", end_cyc, 9);
    check_val("s5b_done", done_cnt, 1);
    exp_count += 32'd1;
    check_val("s5b_count", pkt_count, exp_count);

    // 6: cfg_len = 0 gives single-beat packets, all last
    set_cfg(0, 3, 0, 1'b1);
    pulse_start();
    collect_run(50);
    check_val("s6_beats", bd.size(), 3);
    check_val("s6_d0", got_d(0), 0);
    check_val("s6_d2", got_d(2), 0);
    check_val("s6_last", pack_last(), 32'b111);
    check_val("s6_done", done_cnt, 3);
    exp_count += 32'd3;
    check_val("s6_count", pkt_count, exp_count);

    // 6: reset mid-packet aborts; LFSR restarts from the seed
    set_cfg(4, 0, 0, 1'b0);
    pulse_start();
    tick();
    rst = 1'b1;
    tick();
    check_val("abort_valid", m_valid, 0);
    check_val("abort_data", m_data, 0);
    check_val("abort_last", m_last, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_done", pkt_done, 0);
    check_val("abort_count", pkt_count, 0);
    rst       = 1'b0;
    exp_lfsr  = SEED;
    exp_count = 32'd0;
    set_cfg(1, 1, 0, 1'b0);
    pulse_start();
    check_val("abort_first_word", m_data, 32'hACE11234);
    collect_run(50);
    check_val("abort_beats", bd.size(), 1);
    check_val("abort_run_last", pack_last(), 32'b1);
    exp_count += 32'd1;
    check_val("abort_run_count", pkt_count, exp_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lfsr_stream_packet_gen.md
Name: lfsr_stream_packet_gen

Overview:
Parametrised successor to the fixed-size LFSR packet generator, for network traffic generation on Kintex-7. Emits a programmable number of packets over a valid/ready streaming interface with runtime length, inter-packet gap, last-beat marking and a PRBS or incrementing-count payload mode. Sits between the host control registers and any streaming sink (MAC, FIFO, checker). Synthesizable, no vendor IP.

Parameters:
DATA_W, 32, payload width in bits (1..256); NLANES = ceil(DATA_W/32) independent 32-bit LFSR lanes
LFSR_SEED, 32'hACE1_1234, seed of lane 0; lane k seed = LFSR_SEED ^ (k * 32'h9E37_79B9); a computed seed of 0 is replaced by 32'h0000_0001
LEN_W, 16, width of the packet-length field
GAP_W, 8, width of the inter-packet-gap field

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request; accepted only in IDLE
stop  in  1  graceful stop request; sticky until honoured
cfg_len  in  LEN_W  words per packet; 0 treated as 1
cfg_num_pkts  in  16  packets per run; 0 = continuous until stop
cfg_gap  in  GAP_W  idle cycles between packets
cfg_mode  in  1  0 = PRBS payload, 1 = word-index payload
m_data  out  DATA_W  payload word
m_valid  out  1  m_data is valid
m_last  out  1  marks final word of a packet
m_ready  in  1  sink accepts the beat when m_valid & m_ready
busy  out  1  high in SEND or GAP
pkt_done  out  1  one-cycle pulse per completed packet
pkt_count  out  32  packets completed since reset; wraps modulo 2^32

Behaviour:
- Reset: all outputs 0, state IDLE, LFSR lanes reseeded, pending stop cleared. Reset mid-packet aborts immediately; outputs are 0 in the cycle after rst is sampled.
- cfg_* latched on the start cycle; later changes are ignored until the next run.
- States: IDLE -> SEND on start. SEND -> GAP after the last-beat handshake when more packets remain and gap > 0. SEND -> SEND when gap = 0 and more packets remain. SEND -> IDLE when the run is complete or stop is pending. GAP -> SEND after exactly cfg_gap idle cycles. GAP -> IDLE immediately if stop is pending.
- Latency: start sampled in cycle N -> first beat has m_valid = 1 in cycle N+1.
- Handshake: a transfer occurs when m_valid & m_ready. While m_valid & !m_ready, m_data and m_last stay stable, and neither the LFSR nor the word index advances. m_valid never drops mid-packet.
- PRBS mode: each lane is a Fibonacci LFSR with x^32+x^22+x^2+x+1, fb = s[31]^s[21]^s[1]^s[0], next = {s[30:0], fb}. m_data = {lane NLANES-1 .. lane 0} truncated to DATA_W. Every lane advances once per transfer. The LFSR is not reseeded between packets or runs; only rst reseeds it.
- Word-index mode: m_data = word index within the packet (0..len-1), zero-extended or truncated to DATA_W. LFSR still advances per transfer.
- m_last = 1 exactly on word index len-1; when len = 1 (cfg_len 0 or 1), every beat is last.
- Back-to-back: with gap = 0, the next packet's first beat is valid in the cycle after the last handshake, with no bubble.
- With gap > 0, m_valid = 0 for exactly cfg_gap cycles between the last handshake and the next first beat.
- pkt_done pulses in the cycle after each last handshake. pkt_count increments in that same cycle.
- busy falls in the same cycle the FSM enters IDLE.
- start while busy: ignored. stop in IDLE: ignored and not stored.
- stop in SEND: the current packet completes, then the FSM returns to IDLE.
- Run-count counter is 16-bit; cfg_num_pkts = 65535 sends exactly 65535 packets.

Test Plan:
1. After reset, set len=4, num=1, gap=0, mode=0, m_ready=1, pulse start -> 4 beats starting the next cycle; m_data = 32'hACE11234 then 32'h59C22468; m_last on beat 4 only; pkt_done pulses once; pkt_count = 1; busy returns low.
2. Same as scenario 1 with m_ready held low for 3 cycles at beat 2 -> data and m_last held stable; beat 3 = LFSR successor of beat 2; exactly 4 transfers total.
3. len=4, num=3, gap=2, mode=1 -> payload 0,1,2,3 repeated 3 times; exactly 2 m_valid=0 cycles between packets; pkt_count = 3.
4. len=5, num=2, gap=0 -> m_valid continuously high for 10 cycles; m_last on beats 5 and 10; start pulsed mid-run has no effect.
5. num=0, len=8: assert stop during beat 2 -> all 8 beats sent, then IDLE. Repeat with gap=6 and stop asserted in GAP -> IDLE next cycle with no further beats.
6. cfg_len=0 -> single-beat packets with m_last=1. Assert rst mid-packet -> outputs 0; the next run's first word is 32'hACE11234.
